microseq: RTL and testbench
===========================

MICROSEQ -- requirements
Module: microseq

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode width taken from the top bits of ir_in.
REQ-002 Parameter FLAG_W, default 2, flag register width (bit 1 = carry C, bit 0 = zero Z).
REQ-003 Parameter STEPS, default 5, number of micro-steps per instruction (range 3..16; need not be a power of 2).
REQ-004 Derived constant STEP_W = clog2(STEPS), the step counter width.
REQ-005 Port: clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 Port: rst  in  1  reset, synchronous and active-high.
REQ-007 Port: en  in  1  sequencer advance enable.
REQ-008 Port: ir_in  in  8  bus value captured by the instruction register.
REQ-009 Port: flags_in  in  FLAG_W  ALU flags captured by the flag register.
REQ-010 Port: ctrl  out  18  control word (bit 17 HLT … bit 0 NOn); bits named *n are active-low.
REQ-011 Port: step  out  STEP_W  current micro-step.
REQ-012 Port: opcode  out  OPCODE_W  current instruction-register opcode.
REQ-013 Port: flags  out  FLAG_W  current flag register value.
REQ-014 Port: halted  out  1  halt state.

Function
REQ-015 The lookup shall select ctrl from {opcode, flags, step} via the package table; the result is combinational from registered state (zero latency).
REQ-016 The IDLE word shall have every active-low bit = 1 and every active-high bit = 0 (18'h07FFF).
REQ-017 ctrl shall be IDLE whenever rst=1, en=0, or halted=1.
REQ-018 Steps 0 and 1 of every opcode shall be fetch: step 0 = CO|MI; step 1 = RO|II|CE.
REQ-019 Opcodes without a table entry shall execute fetch, then IDLE for the remaining steps.
REQ-020 When en=1, halted=0 and the step is below STEPS-1, step shall increment by 1.
REQ-021 When en=1 and halted=0 at step STEPS-1, step shall wrap to 0.
REQ-022 When en=0, step, opcode and flags shall hold.
REQ-023 When the effective ctrl has II active, opcode shall load ir_in[7:8-OPCODE_W] at the edge.
REQ-024 When the effective ctrl has FI active, flags shall load flags_in at the edge.
REQ-025 When the effective ctrl has HLT=1, halted shall be set at the edge and step shall not advance.
REQ-026 halted shall clear only on rst; en has no effect while halted=1.
REQ-027 Conditional jumps (JC, JZ) shall assert J|IO only if the selected flag is 1 at that step; otherwise the step shall be IDLE.
REQ-028 If II and FI are simultaneously active, both registers shall load in the same cycle.

Reset
REQ-029 With rst=1 at an edge: step=0, opcode=0, flags=0, halted=0; rst overrides en, HLT, II and FI.
REQ-030 In the first cycle after rst deasserts with en=1, ctrl shall equal the step-0 fetch word.

Configuration
REQ-031 With macro MSEQ_EARLY_END_EN defined, when the word for step+1 of the current {opcode, flags} is IDLE and step≥2, step shall return to 0 instead of incrementing.
REQ-032 Without MSEQ_EARLY_END_EN, step shall always walk all STEPS steps (REQ-020/021).

Structure
REQ-033 Package mseq_pkg shall hold: CTRL_W=18, bit-position constants for each control signal, the IDLE constant, opcode constants (NOP=0, LDA=1, ADD=2, SUB=3, STA=4, LDI=5, JMP=6, JC=7, JZ=8, OUT=14, HLT=15), and the function mc_word(opcode, flags, step).
REQ-034 Sub-module mseq_rom shall be a combinational wrapper of mc_word; microseq shall hold only the registers, gating and next-step logic.

Verification
REQ-035 Reset, then en=1 with ir_in=8'h1E -> cycle 0 ctrl=CO|MI; cycle 1 ctrl=RO|II|CE; then opcode=1, step=2.
REQ-036 Run through step 4 with STEPS=5, en=1 -> step sequence 0,1,2,3,4,0.
REQ-037 JC (ir_in=8'h7x): with flags=2'b10, step 2 has J and IO active; with flags=2'b00, step 2 ctrl is IDLE.
REQ-038 HLT (ir_in=8'hF0): at step 2 HLT=1 -> next cycle halted=1, ctrl=IDLE, step frozen at 2 for 10 cycles; rst -> step=0, halted=0.
REQ-039 en toggled low at step 3 for 4 cycles -> ctrl=IDLE, step=3 held; resumes at step 3 when en returns high.
REQ-040 With MSEQ_EARLY_END_EN and OUT (ir_in=8'hE0, step 3 IDLE) -> step sequence 0,1,2,0; without the macro -> 0,1,2,3,4,0.

Source files
------------

// File: rtl/mseq_pkg.sv
// Shared microcode definitions for the microseq sequencer: control-word bit map,
// opcode values and the microcode lookup function mc_word().
package mseq_pkg;

  localparam int CTRL_W = 18;

  // Bits 17..15 are active-high, bits 14..0 are active-low (*n)
  localparam int B_HLT = 17;
  localparam int B_CE  = 16;
  localparam int B_J   = 15;
  localparam int B_MIN = 14;
  localparam int B_RIN = 13;
  localparam int B_RON = 12;
  localparam int B_ION = 11;
  localparam int B_IIN = 10;
  localparam int B_AIN = 9;
  localparam int B_AON = 8;
  localparam int B_EON = 7;
  localparam int B_SUN = 6;
  localparam int B_BIN = 5;
  localparam int B_OIN = 4;
  localparam int B_CON = 3;
  localparam int B_FIN = 2;
  localparam int B_BON = 1;
  localparam int B_NON = 0;

  localparam logic [CTRL_W-1:0] M_HLT = CTRL_W'(1) << B_HLT;
  localparam logic [CTRL_W-1:0] M_CE  = CTRL_W'(1) << B_CE;
  localparam logic [CTRL_W-1:0] M_J   = CTRL_W'(1) << B_J;
  localparam logic [CTRL_W-1:0] M_MI  = CTRL_W'(1) << B_MIN;
  localparam logic [CTRL_W-1:0] M_RI  = CTRL_W'(1) << B_RIN;
  localparam logic [CTRL_W-1:0] M_RO  = CTRL_W'(1) << B_RON;
  localparam logic [CTRL_W-1:0] M_IO  = CTRL_W'(1) << B_ION;
  localparam logic [CTRL_W-1:0] M_II  = CTRL_W'(1) << B_IIN;
  localparam logic [CTRL_W-1:0] M_AI  = CTRL_W'(1) << B_AIN;
  localparam logic [CTRL_W-1:0] M_AO  = CTRL_W'(1) << B_AON;
  localparam logic [CTRL_W-1:0] M_EO  = CTRL_W'(1) << B_EON;
  localparam logic [CTRL_W-1:0] M_SU  = CTRL_W'(1) << B_SUN;
  localparam logic [CTRL_W-1:0] M_BI  = CTRL_W'(1) << B_BIN;
  localparam logic [CTRL_W-1:0] M_OI  = CTRL_W'(1) << B_OIN;
  localparam logic [CTRL_W-1:0] M_CO  = CTRL_W'(1) << B_CON;
  localparam logic [CTRL_W-1:0] M_FI  = CTRL_W'(1) << B_FIN;
  localparam logic [CTRL_W-1:0] M_BO  = CTRL_W'(1) << B_BON;
  localparam logic [CTRL_W-1:0] M_NO  = CTRL_W'(1) << B_NON;

  // Idle = every active-low line released, every active-high line low (18'h07FFF)
  localparam logic [CTRL_W-1:0] IDLE = M_MI | M_RI | M_RO | M_IO | M_II | M_AI | M_AO |
                                       M_EO | M_SU | M_BI | M_OI | M_CO | M_FI | M_BO | M_NO;

  localparam logic [7:0] OP_NOP = 8'd0;
  localparam logic [7:0] OP_LDA = 8'd1;
  localparam logic [7:0] OP_ADD = 8'd2;
  localparam logic [7:0] OP_SUB = 8'd3;
  localparam logic [7:0] OP_STA = 8'd4;
  localparam logic [7:0] OP_LDI = 8'd5;
  localparam logic [7:0] OP_JMP = 8'd6;
  localparam logic [7:0] OP_JC  = 8'd7;
  localparam logic [7:0] OP_JZ  = 8'd8;
  localparam logic [7:0] OP_OUT = 8'd14;
  localparam logic [7:0] OP_HLT = 8'd15;

  // Signals are listed as "active" masks; XOR with IDLE yields the line levels.
  function automatic logic [CTRL_W-1:0] mc_word(input logic [7:0] op,
                                                input logic [1:0] flg,
                                                input logic [7:0] stp);
    logic [CTRL_W-1:0] act;
    act = '0;
    if (stp == 8'd0) begin
      act = M_CO | M_MI;
    end else if (stp == 8'd1) begin
      act = M_RO | M_II | M_CE;
    end else begin
      case (op)
        OP_LDA: case (stp)
          8'd2:    act = M_IO | M_MI;
          8'd3:    act = M_RO | M_AI;
          default: act = '0;
        endcase
        OP_ADD: case (stp)
          8'd2:    act = M_IO | M_MI;
          8'd3:    act = M_RO | M_BI;
          8'd4:    act = M_EO | M_AI | M_FI;
          default: act = '0;
        endcase
        OP_SUB: case (stp)
          8'd2:    act = M_IO | M_MI;
          8'd3:    act = M_RO | M_BI;
          8'd4:    act = M_EO | M_AI | M_SU | M_FI;
          default: act = '0;
        endcase
        OP_STA: case (stp)
          8'd2:    act = M_IO | M_MI;
          8'd3:    act = M_AO | M_RI;
          default: act = '0;
        endcase
        OP_LDI: act = (stp == 8'd2) ? (M_IO | M_AI) : '0;
        OP_JMP: act = (stp == 8'd2) ? (M_IO | M_J) : '0;
        OP_JC:  act = (stp == 8'd2 && flg[1]) ? (M_IO | M_J) : '0;
        OP_JZ:  act = (stp == 8'd2 && flg[0]) ? (M_IO | M_J) : '0;
        OP_OUT: act = (stp == 8'd2) ? (M_AO | M_OI) : '0;
        OP_HLT: act = (stp == 8'd2) ? M_HLT : '0;
        OP_NOP: act = '0;
        default: act = '0;
      endcase
    end
    return IDLE ^ act;
  endfunction

endpackage

// File: rtl/microseq_if.sv
// Bus bundle between the microseq sequencer (slave) and its driver (master).
interface microseq_if
  import mseq_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FLAG_W   = 2,
  parameter int STEPS    = 5
);
  localparam int STEP_W = $clog2(STEPS);

  logic                en;
  logic [7:0]          ir_in;
  logic [FLAG_W-1:0]   flags_in;
  logic [CTRL_W-1:0]   ctrl;
  logic [STEP_W-1:0]   step;
  logic [OPCODE_W-1:0] opcode;
  logic [FLAG_W-1:0]   flags;
  logic                halted;

  modport master (output en, ir_in, flags_in, input ctrl, step, opcode, flags, halted);
  modport slave  (input en, ir_in, flags_in, output ctrl, step, opcode, flags, halted);
endinterface

// File: rtl/mseq_rom.sv
// Combinational microcode lookup: ctrl word for a given {opcode, flags, step}.
module mseq_rom
  import mseq_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FLAG_W   = 2,
  parameter int STEP_W   = 3
) (
  input  logic [OPCODE_W-1:0] op,
  input  logic [FLAG_W-1:0]   flags,
  input  logic [STEP_W:0]     stp,
  output logic [CTRL_W-1:0]   word
);
  assign word = mc_word(8'(op), flags[1:0], 8'(stp));
endmodule

// File: rtl/microseq.sv
// Microcode sequencer: step counter, instruction/flag registers and halt latch.
// Optional MSEQ_EARLY_END_EN: return to step 0 once the remaining steps are idle.
module microseq
  import mseq_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FLAG_W   = 2,
  parameter int STEPS    = 5,
  localparam int STEP_W  = $clog2(STEPS)
) (
  input  logic       clk,
  input  logic       rst,
  microseq_if.slave  bus
);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  logic [STEP_W-1:0]   step_q, step_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                halted_q, halted_d;
  logic [CTRL_W-1:0]   rom_word, ctrl_eff;
  logic                early_end;
  logic                unused_ir;

  assign unused_ir = ^bus.ir_in[7-OPCODE_W:0];

  mseq_rom #(.OPCODE_W(OPCODE_W), .FLAG_W(FLAG_W), .STEP_W(STEP_W)) u_rom (
    .op    (opcode_q),
    .flags (flags_q),
    .stp   ({1'b0, step_q}),
    .word  (rom_word)
  );

`ifdef MSEQ_EARLY_END_EN
  logic [CTRL_W-1:0] next_word;

  mseq_rom #(.OPCODE_W(OPCODE_W), .FLAG_W(FLAG_W), .STEP_W(STEP_W)) u_rom_next (
    .op    (opcode_q),
    .flags (flags_q),
    .stp   ({1'b0, step_q} + 1'b1),
    .word  (next_word)
  );

  assign early_end = (next_word == IDLE) && (step_q >= STEP_W'(2));
`else
  assign early_end = 1'b0;
`endif

  // Register loads follow the gated word, so en=0 / halted / rst suppress II and FI
  assign ctrl_eff = (rst || !bus.en || halted_q) ? IDLE : rom_word;

  always_comb begin
    step_d   = step_q;
    opcode_d = opcode_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    if (bus.en && !halted_q) begin
      if (ctrl_eff[B_HLT])                     halted_d = 1'b1;
      else if (step_q == LAST_STEP || early_end) step_d = '0;
      else                                     step_d = step_q + 1'b1;
    end
    if (!ctrl_eff[B_IIN]) opcode_d = bus.ir_in[7 -: OPCODE_W];
    if (!ctrl_eff[B_FIN]) flags_d  = bus.flags_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= '0;
      opcode_q <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      opcode_q <= opcode_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  assign bus.ctrl   = ctrl_eff;
  assign bus.step   = step_q;
  assign bus.opcode = opcode_q;
  assign bus.flags  = flags_q;
  assign bus.halted = halted_q;
endmodule

// File: tb/tb_microseq.sv
// Self-checking bench for microseq: directed scenarios plus random traffic
// compared every cycle against an instruction-level reference model.
module tb_microseq;
  localparam int STEPS = 5;
  localparam logic [17:0] IDLE_W = 18'h07FFF;

  localparam int P_HLT = 17, P_CE = 16, P_J = 15, P_MI = 14, P_RI = 13, P_RO = 12;
  localparam int P_IO = 11, P_II = 10, P_AI = 9, P_AO = 8, P_EO = 7, P_SU = 6;
  localparam int P_BI = 5, P_OI = 4, P_CO = 3, P_FI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  microseq_if #(.OPCODE_W(4), .FLAG_W(2), .STEPS(STEPS)) bus ();
  microseq #(.OPCODE_W(4), .FLAG_W(2), .STEPS(STEPS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  int m_step, m_op, m_flags;
  bit m_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction semantics: which named signals are active at each step
  function automatic logic [17:0] m_word(input int op, input int fl, input int s);
    int act[$];
    logic [17:0] w;
    bit a;
    act = {};
    if (s == 0) act = {P_CO, P_MI};
    else if (s == 1) act = {P_RO, P_II, P_CE};
    else if (s == 2) begin
      case (op)
        1, 2, 3, 4: act = {P_IO, P_MI};
        5:  act = {P_IO, P_AI};
        6:  act = {P_IO, P_J};
        7:  if ((fl & 2) != 0) act = {P_IO, P_J};
        8:  if ((fl & 1) != 0) act = {P_IO, P_J};
        14: act = {P_AO, P_OI};
        15: act = {P_HLT};
        default: ;
      endcase
    end else if (s == 3) begin
      case (op)
        1:    act = {P_RO, P_AI};
        2, 3: act = {P_RO, P_BI};
        4:    act = {P_AO, P_RI};
        default: ;
      endcase
    end else if (s == 4) begin
      case (op)
        2: act = {P_EO, P_AI, P_FI};
        3: act = {P_EO, P_AI, P_SU, P_FI};
        default: ;
      endcase
    end
    for (int b = 0; b < 18; b++) begin
      a = 1'b0;
      foreach (act[i]) if (act[i] == b) a = 1'b1;
      w[b] = (b >= 15) ? a : !a;
    end
    return w;
  endfunction

  function automatic logic [17:0] m_ctrl(input bit r, input bit e);
    if (r || !e || m_halt) return IDLE_W;
    return m_word(m_op, m_flags, m_step);
  endfunction

  // One clock: drive at negedge, compare just after, then advance the model
  task automatic cyc(input bit r, input bit e, input logic [7:0] ir, input logic [1:0] fl);
    logic [17:0] w;
    int nop, nfl, ns;
    @(negedge clk);
    rst = r; bus.en = e; bus.ir_in = ir; bus.flags_in = fl;
    #1;
    w = m_ctrl(r, e);
    check("ctrl", bus.ctrl, w);
    check("step", bus.step, m_step);
    check("opcode", bus.opcode, m_op);
    check("flags", bus.flags, m_flags);
    check("halted", bus.halted, m_halt);
    if (r) begin
      m_step = 0; m_op = 0; m_flags = 0; m_halt = 0;
    end else begin
      nop = m_op; nfl = m_flags;
      if (!w[P_II]) nop = int'(ir) / 16;
      if (!w[P_FI]) nfl = int'(fl);
      if (e && !m_halt) begin
        if (w[P_HLT]) m_halt = 1;
        else begin
          ns = (m_step + 1) % STEPS;
`ifdef MSEQ_EARLY_END_EN
          if (m_step >= 2 && m_word(m_op, m_flags, m_step + 1) == IDLE_W) ns = 0;
`endif
          m_step = ns;
        end
      end
      m_op = nop; m_flags = nfl;
    end
  endtask

  task automatic finish_instr(input logic [7:0] ir, input logic [1:0] fl);
    int n = 0;
    while (m_step != 0 && n < 20) begin
      cyc(1'b0, 1'b1, ir, fl);
      n++;
    end
    check("instr_bound", n < 20, 1);
  endtask

`ifdef MSEQ_EARLY_END_EN
  int out_seq[$] = {0, 1, 2, 0};
`else
  int out_seq[$] = {0, 1, 2, 3, 4, 0};
`endif

  initial begin
    bit r, e;
    rst = 1'b1; bus.en = 1'b0; bus.ir_in = '0; bus.flags_in = '0;
    m_step = 0; m_op = 0; m_flags = 0; m_halt = 0;

    @(negedge clk);
    rst = 1'b1; bus.en = 1'b1;
    #1 check("rst_idle", bus.ctrl, IDLE_W);
    cyc(1'b1, 1'b1, 8'h1E, 2'b00);

    // Fetch of LDA
    cyc(1'b0, 1'b1, 8'h1E, 2'b00); check("fetch0", bus.ctrl, 18'h03FF7);
    cyc(1'b0, 1'b1, 8'h1E, 2'b00); check("fetch1", bus.ctrl, 18'h16BFF);
    cyc(1'b0, 1'b1, 8'h1E, 2'b00); check("lda_op", bus.opcode, 1); check("lda_step", bus.step, 2);
    finish_instr(8'h1E, 2'b00);

    // ADD walks every step and loads C=1 on its last step
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 8'h2A, 2'b10);
      check("walk_step", bus.step, i % STEPS);
    end
    cyc(1'b0, 1'b1, 8'h70, 2'b00);
    cyc(1'b0, 1'b1, 8'h70, 2'b00);
    check("jc_flags", bus.flags, 2'b10);
    check("jc_j", bus.ctrl[P_J], 1'b1);
    check("jc_io", bus.ctrl[P_IO], 1'b0);
    finish_instr(8'h70, 2'b00);

    // ADD clears flags, then JC falls through
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h2A, 2'b00);
    cyc(1'b0, 1'b1, 8'h70, 2'b11);
    cyc(1'b0, 1'b1, 8'h70, 2'b11);
    cyc(1'b0, 1'b1, 8'h70, 2'b11);
    check("jc_nottaken", bus.ctrl, IDLE_W);
    finish_instr(8'h70, 2'b11);

    // HLT
    cyc(1'b0, 1'b1, 8'hF0, 2'b00);
    cyc(1'b0, 1'b1, 8'hF0, 2'b00);
    cyc(1'b0, 1'b1, 8'hF0, 2'b00);
    check("hlt_bit", bus.ctrl[P_HLT], 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8'hF0, 2'b11);
      check("halt_flag", bus.halted, 1'b1);
      check("halt_ctrl", bus.ctrl, IDLE_W);
      check("halt_step", bus.step, 2);
    end
    cyc(1'b1, 1'b1, 8'h1E, 2'b00);
    cyc(1'b0, 1'b1, 8'h1E, 2'b00);
    check("unhalt_step", bus.step, 0);
    check("unhalt_flag", bus.halted, 1'b0);
    check("unhalt_fetch", bus.ctrl, 18'h03FF7);

    // en low at step 3 of LDA
    cyc(1'b0, 1'b1, 8'h1E, 2'b00);
    cyc(1'b0, 1'b1, 8'h1E, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 8'hF0, 2'b11);
      check("en_idle", bus.ctrl, IDLE_W);
      check("en_hold", bus.step, 3);
    end
    cyc(1'b0, 1'b1, 8'h1E, 2'b00);
    check("en_resume_step", bus.step, 3);
    check("en_resume_ctrl", bus.ctrl, 18'h06DFF);
    finish_instr(8'h1E, 2'b00);

    // OUT step sequence
    foreach (out_seq[i]) begin
      cyc(1'b0, 1'b1, 8'hE0, 2'b00);
      check("out_seq", bus.step, out_seq[i]);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = (m_halt && ($urandom % 4 == 0)) || ($urandom % 300 == 0);
      e = ($urandom % 6) != 0;
      cyc(r, e, 8'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
